// File: rtl/conv_pkg.sv
// Shared types and widths for the two-stage 3x3 convolution engine.
package conv_pkg;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned W_W   = 8;
  localparam int unsigned ACC_W = 32;
  localparam int unsigned MAP_W = 24;
  localparam int unsigned OPD_W = MAP_W + 1;
  localparam int unsigned WIN   = 9;

  typedef enum logic [1:0] {IDLE, C1, C2, DONE} state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv3x3_mac.sv
// Nine signed products of a 3x3 window summed into an ACC_W accumulator.
module conv3x3_mac
  import conv_pkg::*;
(
  input  logic signed [OPD_W-1:0] win_i [WIN],
  input  logic signed [W_W-1:0]   wgt_i [WIN],
  output logic signed [ACC_W-1:0] acc_o
);

  always_comb begin
    acc_o = '0;
    for (int unsigned i = 0; i < WIN; i++) begin
      acc_o = acc_o + ACC_W'(win_i[i]) * ACC_W'(wgt_i[i]);
    end
  end

endmodule

// File: rtl/conv.sv
// Two-stage 3x3 valid convolution engine, one channel at a time, one pixel per cycle.
module conv
  import conv_pkg::*;
#(
  parameter int unsigned K_H    = 3,
  parameter int unsigned K_W    = 3,
  parameter int unsigned IN1_H  = 16,
  parameter int unsigned IN1_W  = 15,
  parameter int unsigned OUT1_H = IN1_H - K_H + 1,
  parameter int unsigned OUT1_W = IN1_W - K_W + 1,
  parameter int unsigned OUT2_H = OUT1_H - K_H + 1,
  parameter int unsigned OUT2_W = OUT1_W - K_W + 1,
  parameter int unsigned CHAN   = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    trigger,
  input  logic [PIX_W-1:0]        in_img   [IN1_H][IN1_W],
  input  logic signed [W_W-1:0]   w_conv1  [K_H][K_W][CHAN],
  input  logic signed [W_W-1:0]   w_conv2  [K_H][K_W][CHAN],
  output logic signed [MAP_W-1:0] out_buff [OUT2_H][OUT2_W],
  output logic                    out_valid,
  output logic [3:0]              out_chan
);

  localparam int unsigned IR_W  = idx_w(IN1_H);
  localparam int unsigned IC_W  = idx_w(IN1_W);
  localparam int unsigned MR_W  = idx_w(OUT1_H);
  localparam int unsigned MC_W  = idx_w(OUT1_W);
  localparam int unsigned OR_W  = idx_w(OUT2_H);
  localparam int unsigned OC_W  = idx_w(OUT2_W);
  localparam int unsigned CH_W  = idx_w(CHAN);
  localparam int unsigned CNT_W = idx_w((OUT1_H > OUT1_W) ? OUT1_H : OUT1_W);

  typedef logic [CNT_W-1:0] cnt_t;

  state_t                   state_q;
  cnt_t                     row_q, col_q;
  logic [3:0]               ch_q;
  logic                     trig_prev_q;
  logic                     out_valid_q;
  logic [3:0]               out_chan_q;
  logic [MAP_W-1:0]         map_q [OUT1_H][OUT1_W];
  logic signed [MAP_W-1:0]  out_q [OUT2_H][OUT2_W];

  logic signed [OPD_W-1:0]  win [WIN];
  logic signed [W_W-1:0]    wgt [WIN];
  logic signed [ACC_W-1:0]  acc;

  // Single MAC shared by both stages: window and kernel selected by the current stage.
  always_comb begin
    for (int unsigned ky = 0; ky < K_H; ky++) begin
      for (int unsigned kx = 0; kx < K_W; kx++) begin
        win[ky*K_W+kx] = '0;
        wgt[ky*K_W+kx] = '0;
        if (state_q == C1) begin
          win[ky*K_W+kx] = OPD_W'(in_img[IR_W'(row_q + ky)][IC_W'(col_q + kx)]);
          wgt[ky*K_W+kx] = w_conv1[ky][kx][CH_W'(ch_q)];
        end else if (state_q == C2) begin
          win[ky*K_W+kx] = OPD_W'(map_q[MR_W'(row_q + ky)][MC_W'(col_q + kx)]);
          wgt[ky*K_W+kx] = w_conv2[ky][kx][CH_W'(ch_q)];
        end
      end
    end
  end

  conv3x3_mac u_mac (
    .win_i (win),
    .wgt_i (wgt),
    .acc_o (acc)
  );

  // out_valid/out_chan are registered from DONE, so the pulse trails DONE by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      ch_q        <= '0;
      trig_prev_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      for (int unsigned r = 0; r < OUT1_H; r++)
        for (int unsigned c = 0; c < OUT1_W; c++)
          map_q[r][c] <= '0;
      for (int unsigned r = 0; r < OUT2_H; r++)
        for (int unsigned c = 0; c < OUT2_W; c++)
          out_q[r][c] <= '0;
    end else begin
      trig_prev_q <= trigger;
      out_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (trigger && !trig_prev_q) begin
            state_q <= C1;
            row_q   <= '0;
            col_q   <= '0;
            ch_q    <= '0;
          end
        end
        C1: begin
          map_q[MR_W'(row_q)][MC_W'(col_q)] <= (acc < 0) ? '0 : acc[MAP_W-1:0];
          if (col_q == cnt_t'(OUT1_W - 1)) begin
            col_q <= '0;
            if (row_q == cnt_t'(OUT1_H - 1)) begin
              row_q   <= '0;
              state_q <= C2;
            end else begin
              row_q <= row_q + 1'b1;
            end
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        C2: begin
          out_q[OR_W'(row_q)][OC_W'(col_q)] <= acc[MAP_W-1:0];
          if (col_q == cnt_t'(OUT2_W - 1)) begin
            col_q <= '0;
            if (row_q == cnt_t'(OUT2_H - 1)) begin
              row_q   <= '0;
              state_q <= DONE;
            end else begin
              row_q <= row_q + 1'b1;
            end
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        DONE: begin
          out_valid_q <= 1'b1;
          out_chan_q  <= ch_q;
          if (ch_q == 4'(CHAN - 1)) begin
            state_q <= IDLE;
          end else begin
            ch_q    <= ch_q + 1'b1;
            state_q <= C1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_buff  = out_q;
  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_conv.sv
// Directed-vector bench for conv with CHAN=4 and a reference model for the random case.
module tb_conv;

  localparam int CH = 4;

  logic clk = 1'b0;
  logic rst;
  logic trigger;
  logic [7:0]         img [16][15];
  logic signed [7:0]  w1  [3][3][CH];
  logic signed [7:0]  w2  [3][3][CH];
  logic signed [23:0] ob  [12][11];
  logic               ov;
  logic [3:0]         oc;

  logic signed [23:0] exp_map [12][11];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv #(.CHAN(CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .trigger   (trigger),
    .in_img    (img),
    .w_conv1   (w1),
    .w_conv2   (w2),
    .out_buff  (ob),
    .out_valid (ov),
    .out_chan  (oc)
  );

  task automatic fill_inputs(input int pix, input int wa, input int wb);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 15; c++)
        img[r][c] = 8'(pix);
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 3; x++)
        for (int k = 0; k < CH; k++) begin
          w1[y][x][k] = 8'(wa);
          w2[y][x][k] = 8'(wb);
        end
  endtask

  task automatic set_exp(input int v);
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 11; c++)
        exp_map[r][c] = 24'(v);
  endtask

  function automatic void golden(input int ch);
    longint m1 [14][13];
    longint a;
    for (int r = 0; r < 14; r++)
      for (int c = 0; c < 13; c++) begin
        a = 0;
        for (int y = 0; y < 3; y++)
          for (int x = 0; x < 3; x++)
            a += longint'(img[r+y][c+x]) * longint'(w1[y][x][ch]);
        m1[r][c] = (a < 0) ? 0 : (a & 64'h00FF_FFFF);
      end
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 11; c++) begin
        a = 0;
        for (int y = 0; y < 3; y++)
          for (int x = 0; x < 3; x++)
            a += m1[r+y][c+x] * longint'(w2[y][x][ch]);
        exp_map[r][c] = a[23:0];
      end
  endfunction

  function automatic int count_bad(output int br, output int bc);
    int n = 0;
    br = 0;
    bc = 0;
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 11; c++)
        if (ob[r][c] !== exp_map[r][c]) begin
          if (n == 0) begin
            br = r;
            bc = c;
          end
          n++;
        end
    return n;
  endfunction

  task automatic pulse_trigger();
    @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic wait_pulse(input int budget, output int cyc, output bit seen);
    cyc  = 0;
    seen = 1'b0;
    while (cyc < budget && !seen) begin
      @(negedge clk);
      cyc++;
      if (ov === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    int br, bc, nb;
    rst = 1'b1;
    trigger = 1'b0;
    repeat (3) @(negedge clk);
    set_exp(0);
    checks++;
    if (ov !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ov); end
    checks++;
    if (oc !== 4'd0) begin errors++; $display("FAIL reset_chan got %0d want 0", oc); end
    nb = count_bad(br, bc);
    checks++;
    if (nb !== 0) begin
      errors++;
      $display("FAIL reset_buff %0d bad, [%0d][%0d] got %0d want 0", nb, br, bc, ob[br][bc]);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ones();
    int cyc, br, bc, nb;
    bit seen;
    fill_inputs(1, 1, 1);
    set_exp(81);
    pulse_trigger();
    for (int ch = 0; ch < CH; ch++) begin
      wait_pulse(400, cyc, seen);
      checks++;
      if (!seen || cyc + 1 !== ((ch == 0) ? 316 : 315)) begin
        errors++;
        $display("FAIL ones_latency ch%0d seen %0b got %0d cycles want %0d", ch, seen, cyc + 1,
                 (ch == 0) ? 316 : 315);
      end
      checks++;
      if (oc !== 4'(ch)) begin errors++; $display("FAIL ones_chan got %0d want %0d", oc, ch); end
      nb = count_bad(br, bc);
      checks++;
      if (nb !== 0) begin
        errors++;
        $display("FAIL ones_map ch%0d %0d bad, [%0d][%0d] got %0d want 81", ch, nb, br, bc, ob[br][bc]);
      end
      @(negedge clk);
      checks++;
      if (ov !== 1'b0) begin errors++; $display("FAIL ones_width ch%0d got %b want 0", ch, ov); end
    end
  endtask

  task automatic test_relu();
    int cyc, br, bc, nb;
    bit seen;
    fill_inputs(255, -1, 37);
    set_exp(0);
    pulse_trigger();
    for (int ch = 0; ch < CH; ch++) begin
      wait_pulse(400, cyc, seen);
      checks++;
      if (!seen || oc !== 4'(ch)) begin
        errors++;
        $display("FAIL relu_pulse seen %0b got chan %0d want %0d", seen, oc, ch);
      end
      nb = count_bad(br, bc);
      checks++;
      if (nb !== 0) begin
        errors++;
        $display("FAIL relu_map ch%0d %0d bad, [%0d][%0d] got %0d want 0", ch, nb, br, bc, ob[br][bc]);
      end
    end
  endtask

  task automatic test_wrap();
    int cyc, br, bc, nb, want;
    bit seen;
    fill_inputs(255, 127, 127);
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 3; x++) begin
        w2[y][x][2] = -8'sd128;
        w2[y][x][3] = -8'sd128;
      end
    pulse_trigger();
    for (int ch = 0; ch < CH; ch++) begin
      want = (ch < 2) ? -2399825 : -223360;
      set_exp(want);
      wait_pulse(400, cyc, seen);
      checks++;
      if (!seen || oc !== 4'(ch)) begin
        errors++;
        $display("FAIL wrap_pulse seen %0b got chan %0d want %0d", seen, oc, ch);
      end
      nb = count_bad(br, bc);
      checks++;
      if (nb !== 0) begin
        errors++;
        $display("FAIL wrap_map ch%0d %0d bad, [%0d][%0d] got %0d want %0d", ch, nb, br, bc,
                 ob[br][bc], want);
      end
    end
  endtask

  task automatic test_random();
    int cyc, br, bc, nb;
    bit seen;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 15; c++)
        img[r][c] = 8'($urandom_range(255));
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 3; x++)
        for (int k = 0; k < CH; k++) begin
          w1[y][x][k] = 8'($urandom_range(255));
          w2[y][x][k] = 8'($urandom_range(255));
        end
    pulse_trigger();
    for (int ch = 0; ch < CH; ch++) begin
      golden(ch);
      wait_pulse(400, cyc, seen);
      checks++;
      if (!seen || oc !== 4'(ch)) begin
        errors++;
        $display("FAIL random_pulse seen %0b got chan %0d want %0d", seen, oc, ch);
      end
      nb = count_bad(br, bc);
      checks++;
      if (nb !== 0) begin
        errors++;
        $display("FAIL random_map ch%0d %0d bad, [%0d][%0d] got %0d want %0d", ch, nb, br, bc,
                 ob[br][bc], exp_map[br][bc]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc, br, bc, nb;
    bit seen;
    fill_inputs(1, 1, 1);
    pulse_trigger();
    wait_pulse(400, cyc, seen);
    repeat (250) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    set_exp(0);
    checks++;
    if (ov !== 1'b0 || oc !== 4'd0) begin
      errors++;
      $display("FAIL midreset_outs got valid %b chan %0d want 0 0", ov, oc);
    end
    nb = count_bad(br, bc);
    checks++;
    if (nb !== 0) begin
      errors++;
      $display("FAIL midreset_buff %0d bad, [%0d][%0d] got %0d want 0", nb, br, bc, ob[br][bc]);
    end
    rst = 1'b0;
    wait_pulse(1000, cyc, seen);
    checks++;
    if (seen) begin errors++; $display("FAIL midreset_nopulse got pulse at %0d want none", cyc); end
  endtask

  task automatic test_trigger_hold();
    int n = 0;
    int first = -1;
    int bad_seq = 0;
    for (int i = 0; i < 1700; i++) begin
      @(negedge clk);
      if (ov === 1'b1) begin
        if (first < 0) first = i;
        if (oc !== 4'(n)) bad_seq++;
        n++;
      end
      trigger = (i < 50) || (i == 100);
    end
    trigger = 1'b0;
    checks++;
    if (n !== CH) begin errors++; $display("FAIL hold_count got %0d pulses want %0d", n, CH); end
    checks++;
    if (first !== 316) begin errors++; $display("FAIL hold_first got %0d want 316", first); end
    checks++;
    if (bad_seq !== 0) begin errors++; $display("FAIL hold_order got %0d out-of-order want 0", bad_seq); end
  endtask

  initial begin
    rst = 1'b1;
    trigger = 1'b0;
    fill_inputs(0, 0, 0);
    test_reset();
    test_ones();
    test_relu();
    test_wrap();
    test_random();
    test_reset_mid_run();
    test_trigger_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
